// File: rtl/lim_cnt_chain.sv
// lim_cnt_chain: N-digit cascade of limited counters for the stopwatch datapath.
// Digit i counts 0..L_i-1. It carries into digit i+1 when counting up and
// borrows from digit i+1 when counting down.
// At the chain ends the count either wraps (pulsing co) or saturates.
// Priority on each edge: reset > clr > load > en.
module lim_cnt_chain #(
  parameter int               N      = 4,
  parameter int               W      = 4,
  parameter logic [N*W-1:0]   LIMITS = {4'd6, 4'd10, 4'd6, 4'd10},
  parameter bit               WRAP   = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           load,
  input  logic [N*W-1:0] load_val,
  input  logic           en,
  input  logic           dir,
  output logic [N*W-1:0] value,
  output logic           co,
  output logic           load_err,
  output logic           at_max,
  output logic           at_min
);

  logic [N*W-1:0] step_val;
  logic           chain_c;
  logic [W:0]     s_d;
  logic [W:0]     s_lim_m1;

  logic [N*W-1:0] clamp_val;
  logic           clamp_any;
  logic [W:0]     c_d;
  logic [W:0]     c_lim_m1;

  logic [W:0]     m_d;
  logic [W:0]     m_lim_m1;

  // Next value for one count step. The carry or borrow ripples through every
  // digit. Arithmetic is W+1 bits wide so digit+1 cannot overflow before the
  // limit compare.
  always_comb begin
    step_val = '0;
    chain_c  = 1'b1;
    s_d      = '0;
    s_lim_m1 = '0;
    for (int i = 0; i < N; i++) begin
      s_d      = {1'b0, value[i*W +: W]};
      s_lim_m1 = {1'b0, LIMITS[i*W +: W]} - (W+1)'(1);
      if (!dir) begin
        if (chain_c && (s_d == s_lim_m1)) begin
          step_val[i*W +: W] = '0;
        end else begin
          s_d                = s_d + {{W{1'b0}}, chain_c};
          step_val[i*W +: W] = s_d[W-1:0];
          chain_c            = 1'b0;
        end
      end else begin
        if (chain_c && (s_d == '0)) begin
          step_val[i*W +: W] = s_lim_m1[W-1:0];
        end else begin
          s_d                = s_d - {{W{1'b0}}, chain_c};
          step_val[i*W +: W] = s_d[W-1:0];
          chain_c            = 1'b0;
        end
      end
    end
  end

  // Clamp each loaded digit to its largest legal value, and flag any digit
  // that was clamped.
  always_comb begin
    clamp_val = '0;
    clamp_any = 1'b0;
    c_d       = '0;
    c_lim_m1  = '0;
    for (int i = 0; i < N; i++) begin
      c_d      = {1'b0, load_val[i*W +: W]};
      c_lim_m1 = {1'b0, LIMITS[i*W +: W]} - (W+1)'(1);
      if (c_d > c_lim_m1) begin
        clamp_val[i*W +: W] = c_lim_m1[W-1:0];
        clamp_any           = 1'b1;
      end else begin
        clamp_val[i*W +: W] = c_d[W-1:0];
      end
    end
  end

  // Chain-end flags, decoded directly from the current value.
  always_comb begin
    at_max   = 1'b1;
    at_min   = 1'b1;
    m_d      = '0;
    m_lim_m1 = '0;
    for (int i = 0; i < N; i++) begin
      m_d      = {1'b0, value[i*W +: W]};
      m_lim_m1 = {1'b0, LIMITS[i*W +: W]} - (W+1)'(1);
      if (m_d != m_lim_m1) at_max = 1'b0;
      if (m_d != '0)       at_min = 1'b0;
    end
  end

  // Count register with prioritised controls. co and load_err are
  // single-cycle pulses and default low on every edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      value    <= '0;
      co       <= 1'b0;
      load_err <= 1'b0;
    end else if (clr) begin
      value    <= '0;
      co       <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      value    <= clamp_val;
      co       <= 1'b0;
      load_err <= clamp_any;
    end else if (en) begin
      load_err <= 1'b0;
      if (chain_c) begin
        // A carry or borrow out of the last digit means the whole chain wraps.
        // In saturating mode the value holds at its end and co stays low.
        if (WRAP) begin
          value <= step_val;
          co    <= 1'b1;
        end else begin
          co    <= 1'b0;
        end
      end else begin
        value <= step_val;
        co    <= 1'b0;
      end
    end else begin
      co       <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lim_cnt_chain.sv
// Testbench for lim_cnt_chain using the default mm:ss limits.
// It runs two instances: one that wraps and one that saturates.
// The reference model holds the count as a single integer (mixed radix) and
// converts it to and from digits.
module tb_lim_cnt_chain;

  logic        clk = 1'b0;
  logic        reset, clr, load, en, dir;
  logic [15:0] load_val;
  logic [15:0] value_w, value_s;
  logic        co_w, co_s, err_w, err_s, max_w, max_s, min_w, min_s;

  int n_chk  = 0;
  int n_fail = 0;

  localparam int M = 3600;
  int lim_tab[4] = '{10, 6, 10, 6};

  int tot_w, tot_s;
  bit mco_w, mco_s, merr_w, merr_s;

  typedef struct {
    logic        reset, clr, load, en, dir;
    logic [15:0] lv;
    logic [15:0] exp_val;
    logic        exp_co, exp_err;
  } vec_t;

  always #5 clk = ~clk;

  lim_cnt_chain #(.WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .value(value_w), .co(co_w), .load_err(err_w),
    .at_max(max_w), .at_min(min_w));

  lim_cnt_chain #(.WRAP(1'b0)) dut_s (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .value(value_s), .co(co_s), .load_err(err_s),
    .at_max(max_s), .at_min(min_s));

  function automatic int to_tot(logic [15:0] v);
    int t = 0;
    int wgt = 1;
    for (int i = 0; i < 4; i++) begin
      t   = t + int'(v[i*4 +: 4]) * wgt;
      wgt = wgt * lim_tab[i];
    end
    return t;
  endfunction

  function automatic logic [15:0] to_val(int t);
    logic [15:0] v = '0;
    int r = t;
    for (int i = 0; i < 4; i++) begin
      v[i*4 +: 4] = 4'(r % lim_tab[i]);
      r           = r / lim_tab[i];
    end
    return v;
  endfunction

  task automatic model_one(input bit wrap, input bit r, input bit c, input bit l,
                           input logic [15:0] lv, input bit e, input bit d,
                           inout int tot, inout bit mco, inout bit merr);
    logic [15:0] cl;
    bit any;
    if (r || c) begin
      tot = 0; mco = 0; merr = 0;
    end else if (l) begin
      any = 0;
      cl  = lv;
      for (int i = 0; i < 4; i++)
        if (int'(lv[i*4 +: 4]) > lim_tab[i] - 1) begin
          cl[i*4 +: 4] = 4'(lim_tab[i] - 1);
          any = 1;
        end
      tot = to_tot(cl); mco = 0; merr = any;
    end else if (e) begin
      mco = 0; merr = 0;
      if (!d) begin
        if (tot == M - 1) begin
          if (wrap) begin tot = 0; mco = 1; end
        end else tot = tot + 1;
      end else begin
        if (tot == 0) begin
          if (wrap) begin tot = M - 1; mco = 1; end
        end else tot = tot - 1;
      end
    end else begin
      mco = 0; merr = 0;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("w_value",  value_w, to_val(tot_w));
    chk("w_co",     16'(co_w), 16'(mco_w));
    chk("w_err",    16'(err_w), 16'(merr_w));
    chk("w_at_max", 16'(max_w), 16'(tot_w == M - 1));
    chk("w_at_min", 16'(min_w), 16'(tot_w == 0));
    chk("s_value",  value_s, to_val(tot_s));
    chk("s_co",     16'(co_s), 16'(mco_s));
    chk("s_err",    16'(err_s), 16'(merr_s));
    chk("s_at_max", 16'(max_s), 16'(tot_s == M - 1));
    chk("s_at_min", 16'(min_s), 16'(tot_s == 0));
  endtask

  task automatic step(input bit r, input bit c, input bit l, input logic [15:0] lv,
                      input bit e, input bit d);
    reset = r; clr = c; load = l; load_val = lv; en = e; dir = d;
    @(posedge clk);
    model_one(1'b1, r, c, l, lv, e, d, tot_w, mco_w, merr_w);
    model_one(1'b0, r, c, l, lv, e, d, tot_s, mco_s, merr_s);
    #1;
    check_model();
  endtask

  vec_t vecs[15];
  bit   co_seen;
  logic [15:0] rv;

  initial begin
    reset = 1; clr = 0; load = 0; load_val = '0; en = 0; dir = 0;
    tot_w = 0; tot_s = 0; mco_w = 0; mco_s = 0; merr_w = 0; merr_s = 0;

    vecs[0]  = '{1,0,0,0,0,16'h0000, 16'h0000,0,0};
    vecs[1]  = '{0,0,1,0,0,16'h5959, 16'h5959,0,0};
    vecs[2]  = '{0,0,0,1,0,16'h0000, 16'h0000,1,0};
    vecs[3]  = '{0,0,0,1,1,16'h0000, 16'h5959,1,0};
    vecs[4]  = '{0,0,0,1,1,16'h0000, 16'h5958,0,0};
    vecs[5]  = '{0,0,1,0,0,16'h7F9C, 16'h5959,0,1};
    vecs[6]  = '{0,0,0,0,0,16'h0000, 16'h5959,0,0};
    vecs[7]  = '{0,1,1,1,0,16'h1234, 16'h0000,0,0};
    vecs[8]  = '{0,0,1,1,0,16'h1234, 16'h1234,0,0};
    vecs[9]  = '{0,0,0,1,0,16'h0000, 16'h1235,0,0};
    vecs[10] = '{0,0,1,0,0,16'h0009, 16'h0009,0,0};
    vecs[11] = '{0,0,0,1,0,16'h0000, 16'h0010,0,0};
    vecs[12] = '{0,0,0,1,1,16'h0000, 16'h0009,0,0};
    vecs[13] = '{0,0,1,0,0,16'h0959, 16'h0959,0,0};
    vecs[14] = '{0,0,0,1,0,16'h0000, 16'h1000,0,0};

    for (int k = 0; k < 15; k++) begin
      step(vecs[k].reset, vecs[k].clr, vecs[k].load, vecs[k].lv, vecs[k].en, vecs[k].dir);
      chk($sformatf("vec%0d_value", k), value_w, vecs[k].exp_val);
      chk($sformatf("vec%0d_co", k), 16'(co_w), 16'(vecs[k].exp_co));
      chk($sformatf("vec%0d_err", k), 16'(err_w), 16'(vecs[k].exp_err));
    end

    // Reset, then 60 up steps: passes 0059 and lands on 0100 with no co.
    step(1, 0, 0, 16'h0, 0, 0);
    chk("rst_at_min", 16'(min_w), 16'h1);
    chk("rst_at_max", 16'(max_w), 16'h0);
    co_seen = 0;
    for (int k = 0; k < 59; k++) begin
      step(0, 0, 0, 16'h0, 1, 0);
      co_seen |= co_w;
    end
    chk("t1_0059", value_w, 16'h0059);
    step(0, 0, 0, 16'h0, 1, 0);
    co_seen |= co_w;
    chk("t1_0100", value_w, 16'h0100);
    chk("t1_no_co", 16'(co_seen), 16'h0);

    // Count down from zero: the wrapping instance goes to max, the
    // saturating instance holds at zero.
    step(1, 0, 0, 16'h0, 0, 0);
    step(0, 0, 0, 16'h0, 1, 1);
    chk("t3_wrap_val", value_w, 16'h5959);
    chk("t3_wrap_co", 16'(co_w), 16'h1);
    chk("t3_sat_val", value_s, 16'h0000);
    chk("t3_sat_co", 16'(co_s), 16'h0);
    step(0, 0, 0, 16'h0, 0, 0);
    chk("t3_co_pulse", 16'(co_w), 16'h0);

    // Saturating instance holds at max when counting up.
    step(0, 0, 1, 16'h5959, 0, 0);
    step(0, 0, 0, 16'h0, 1, 0);
    chk("sat_hold_max", value_s, 16'h5959);
    chk("sat_max_flag", 16'(max_s), 16'h1);

    // Reset applied mid-count at 0457; counting resumes on the next cycle.
    step(0, 0, 1, 16'h0450, 0, 0);
    for (int k = 0; k < 7; k++) step(0, 0, 0, 16'h0, 1, 0);
    chk("t6_pre", value_w, 16'h0457);
    step(1, 0, 0, 16'h0, 1, 0);
    chk("t6_reset", value_w, 16'h0000);
    chk("t6_co", 16'(co_w), 16'h0);
    step(0, 0, 0, 16'h0, 1, 0);
    chk("t6_resume", value_w, 16'h0001);

    // Randomised traffic against the model, with loads biased toward the
    // chain ends so wraps and saturation occur often.
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 3))
        0:       rv = 16'h5959;
        1:       rv = 16'h0000;
        default: rv = 16'($urandom);
      endcase
      step($urandom_range(0, 40) == 0, $urandom_range(0, 20) == 0,
           $urandom_range(0, 9) == 0, rv,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
